// File: rtl/mmio_dmem_arb.sv
// Core/fabric arbiter in front of the single-port data memory. Core has priority;
// fabric requests queue in a FIFO. Define MMIO_DMEM_ARB_STARVE_EN for starvation-forced fabric grants.
module mmio_dmem_arb #(
  parameter int REQ_DEPTH  = 2,
  parameter int RSP_DEPTH  = 2,
  parameter int TAG_W      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             QClk,
  input  logic             RstQnnnL,
  input  logic [31:0]      CoreAdrsQ103H,
  input  logic [31:0]      CoreWrDataQ103H,
  input  logic             CoreWrQ103H,
  input  logic             CoreRdQ103H,
  input  logic [3:0]       CoreByteEnQ103H,
  output logic             CoreStallQ103H,
  output logic [31:0]      CoreRdDataQ104H,
  input  logic             F2mReqValid,
  output logic             F2mReqReady,
  input  logic             F2mReqWr,
  input  logic [31:0]      F2mReqAdrs,
  input  logic [31:0]      F2mReqData,
  input  logic [3:0]       F2mReqByteEn,
  input  logic [TAG_W-1:0] F2mReqTag,
  output logic             M2fRspValid,
  input  logic             M2fRspReady,
  output logic [31:0]      M2fRspData,
  output logic [TAG_W-1:0] M2fRspTag,
  output logic [31:0]      MemAdrs,
  output logic [3:0]       MemByteEn,
  output logic [31:0]      MemWrData,
  output logic             MemRd,
  output logic             MemWr,
  input  logic [31:0]      MemRdData
);
  localparam int RA = $clog2(REQ_DEPTH);
  localparam int SA = $clog2(RSP_DEPTH);
  localparam logic [SA+1:0] RSP_CAP = (SA+2)'(RSP_DEPTH);

  typedef struct packed {
    logic             wr;
    logic [31:0]      adrs;
    logic [31:0]      data;
    logic [3:0]       be;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  req_t             req_mem_q [REQ_DEPTH];
  rsp_t             rsp_mem_q [RSP_DEPTH];
  logic [RA:0]      req_wp_q, req_rp_q;
  logic [SA:0]      rsp_wp_q, rsp_rp_q, rsp_cnt;
  logic             infl_q, infl_wr_q, core_rd_q, rdy_q;
  logic [TAG_W-1:0] infl_tag_q;
  logic [SA+1:0]    outst;
  logic             req_empty, req_full, req_push, rsp_empty, rsp_pop;
  logic             core_req, core_gnt, fab_gnt, issue_ok, forced;
  req_t             req_head;
  rsp_t             rsp_head;

  assign req_empty = (req_wp_q == req_rp_q);
  assign req_full  = (req_wp_q[RA] != req_rp_q[RA]) && (req_wp_q[RA-1:0] == req_rp_q[RA-1:0]);
  assign req_head  = req_mem_q[req_rp_q[RA-1:0]];
  // Ready is held low until the first clock after reset release.
  assign F2mReqReady = rdy_q & ~req_full;
  assign req_push    = F2mReqValid & F2mReqReady;

  assign rsp_empty = (rsp_wp_q == rsp_rp_q);
  assign rsp_cnt   = rsp_wp_q - rsp_rp_q;
  assign rsp_head  = rsp_mem_q[rsp_rp_q[SA-1:0]];
  assign rsp_pop   = ~rsp_empty & M2fRspReady;
  assign M2fRspValid = ~rsp_empty;
  assign M2fRspData  = rsp_empty ? 32'h0 : rsp_head.data;
  assign M2fRspTag   = rsp_empty ? '0 : rsp_head.tag;

  // Credits: a fabric issue needs a guaranteed free response slot.
  assign outst    = {1'b0, rsp_cnt} + (SA+2)'(infl_q);
  assign issue_ok = (outst < RSP_CAP);

  assign core_req = (CoreWrQ103H | CoreRdQ103H) & RstQnnnL;
  assign core_gnt = core_req & ~forced;
  assign fab_gnt  = ~core_gnt & ~req_empty & issue_ok;

`ifdef MMIO_DMEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_MAX);
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (fab_gnt)                                   starve_d = '0;
    else if (!req_empty && starve_q != STARVE_CAP) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge QClk or negedge RstQnnnL)
    if (!RstQnnnL) starve_q <= '0;
    else           starve_q <= starve_d;

  assign forced         = (starve_q == STARVE_CAP) & issue_ok & ~req_empty;
  assign CoreStallQ103H = core_req & fab_gnt;
`else
  assign forced         = 1'b0;
  assign CoreStallQ103H = 1'b0;
`endif

  always_comb begin
    MemAdrs   = 32'h0;
    MemByteEn = 4'h0;
    MemWrData = 32'h0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    if (core_gnt) begin
      MemAdrs   = CoreAdrsQ103H;
      MemByteEn = CoreByteEnQ103H;
      MemWrData = CoreWrDataQ103H;
      MemRd     = CoreRdQ103H;
      MemWr     = CoreWrQ103H;
    end else if (fab_gnt) begin
      MemAdrs   = req_head.adrs;
      MemByteEn = req_head.be;
      MemWrData = req_head.data;
      MemRd     = ~req_head.wr;
      MemWr     = req_head.wr;
    end
  end

  assign CoreRdDataQ104H = core_rd_q ? MemRdData : 32'h0;

  always_ff @(posedge QClk) begin
    if (req_push)
      req_mem_q[req_wp_q[RA-1:0]] <= '{wr: F2mReqWr, adrs: F2mReqAdrs, data: F2mReqData,
                                       be: F2mReqByteEn, tag: F2mReqTag};
    if (infl_q)
      rsp_mem_q[rsp_wp_q[SA-1:0]] <= '{data: infl_wr_q ? 32'h0 : MemRdData, tag: infl_tag_q};
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      req_wp_q   <= '0;
      req_rp_q   <= '0;
      rsp_wp_q   <= '0;
      rsp_rp_q   <= '0;
      infl_q     <= 1'b0;
      infl_wr_q  <= 1'b0;
      infl_tag_q <= '0;
      core_rd_q  <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      if (req_push) req_wp_q <= req_wp_q + 1'b1;
      if (fab_gnt)  req_rp_q <= req_rp_q + 1'b1;
      if (infl_q)   rsp_wp_q <= rsp_wp_q + 1'b1;
      if (rsp_pop)  rsp_rp_q <= rsp_rp_q + 1'b1;
      infl_q     <= fab_gnt;
      infl_wr_q  <= req_head.wr;
      infl_tag_q <= req_head.tag;
      core_rd_q  <= core_gnt & CoreRdQ103H;
    end
  end
endmodule

// File: tb/tb_mmio_dmem_arb.sv
// Scoreboard bench for mmio_dmem_arb: fabric responses are predicted at request time
// and popped as the DUT hands them over; core path and arbitration checked directly.
module tb_mmio_dmem_arb;
  localparam int TAG_W = 4;

  logic             QClk, RstQnnnL;
  logic [31:0]      CoreAdrsQ103H, CoreWrDataQ103H, CoreRdDataQ104H;
  logic             CoreWrQ103H, CoreRdQ103H, CoreStallQ103H;
  logic [3:0]       CoreByteEnQ103H;
  logic             F2mReqValid, F2mReqReady, F2mReqWr;
  logic [31:0]      F2mReqAdrs, F2mReqData;
  logic [3:0]       F2mReqByteEn;
  logic [TAG_W-1:0] F2mReqTag, M2fRspTag;
  logic             M2fRspValid, M2fRspReady;
  logic [31:0]      M2fRspData, MemAdrs, MemWrData, MemRdData;
  logic [3:0]       MemByteEn;
  logic             MemRd, MemWr;

  mmio_dmem_arb #(.REQ_DEPTH(2), .RSP_DEPTH(2), .TAG_W(TAG_W), .STARVE_MAX(8)) dut (
    .QClk(QClk), .RstQnnnL(RstQnnnL),
    .CoreAdrsQ103H(CoreAdrsQ103H), .CoreWrDataQ103H(CoreWrDataQ103H),
    .CoreWrQ103H(CoreWrQ103H), .CoreRdQ103H(CoreRdQ103H), .CoreByteEnQ103H(CoreByteEnQ103H),
    .CoreStallQ103H(CoreStallQ103H), .CoreRdDataQ104H(CoreRdDataQ104H),
    .F2mReqValid(F2mReqValid), .F2mReqReady(F2mReqReady), .F2mReqWr(F2mReqWr),
    .F2mReqAdrs(F2mReqAdrs), .F2mReqData(F2mReqData), .F2mReqByteEn(F2mReqByteEn),
    .F2mReqTag(F2mReqTag),
    .M2fRspValid(M2fRspValid), .M2fRspReady(M2fRspReady), .M2fRspData(M2fRspData),
    .M2fRspTag(M2fRspTag),
    .MemAdrs(MemAdrs), .MemByteEn(MemByteEn), .MemWrData(MemWrData),
    .MemRd(MemRd), .MemWr(MemWr), .MemRdData(MemRdData)
  );

  initial QClk = 1'b0;
  always #5 QClk = ~QClk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    hash = (a == 32'h400) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h13579BDF);
  endfunction

  // Memory model: read data one cycle after MemRd, junk otherwise.
  always @(posedge QClk) MemRdData <= MemRd ? hash(MemAdrs) : $urandom;

  logic [TAG_W+31:0] rsp_q [$];
  logic [TAG_W+31:0] rsp_exp;
  int n_cmp = 0, n_bad = 0, n_rsp = 0, n_rd = 0, n_wr = 0, n_stall = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge QClk) begin
    assert (!(CoreRdQ103H && CoreWrQ103H));
    if (MemRd) n_rd++;
    if (MemWr) n_wr++;
    if (CoreStallQ103H) n_stall++;
    if (RstQnnnL && M2fRspValid && M2fRspReady) begin
      n_rsp++;
      if (rsp_q.size() == 0) chk("rsp_unexp", 64'd1, 64'd0);
      else begin
        rsp_exp = rsp_q.pop_front();
        chk("rsp", {M2fRspTag, M2fRspData}, rsp_exp);
      end
    end
  end

  task automatic tick();
    @(posedge QClk); #1;
  endtask

  task automatic fsend(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [TAG_W-1:0] t);
    int k;
    F2mReqValid = 1'b1; F2mReqWr = wr; F2mReqAdrs = a; F2mReqData = d;
    F2mReqByteEn = 4'hF; F2mReqTag = t;
    for (k = 0; k < 20; k++) begin
      @(negedge QClk);
      if (F2mReqReady) break;
      tick();
    end
    if (k == 20) chk("req_timeout", 64'd0, 64'd1);
    else rsp_q.push_back({t, wr ? 32'h0 : hash(a)});
    tick();
    F2mReqValid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && rsp_q.size() != 0; k++) tick();
    chk(tag, rsp_q.size(), 0);
  endtask

  initial begin
    int rd0, wr0, st0, rsp0, first_wr;
    RstQnnnL = 1'b0; CoreRdQ103H = 1'b1; CoreWrQ103H = 1'b0; CoreAdrsQ103H = 32'h400;
    CoreWrDataQ103H = 32'h0; CoreByteEnQ103H = 4'hF; F2mReqValid = 1'b0; F2mReqWr = 1'b0;
    F2mReqAdrs = 32'h0; F2mReqData = 32'h0; F2mReqByteEn = 4'h0; F2mReqTag = '0;
    M2fRspReady = 1'b1;

    // Reset: core request present but no access may leave the block
    repeat (2) @(negedge QClk);
    chk("rst_memrd", MemRd, 0);
    chk("rst_adrs", MemAdrs, 0);
    chk("rst_stall", CoreStallQ103H, 0);
    chk("rst_rdy", F2mReqReady, 0);
    chk("rst_rspv", M2fRspValid, 0);
    chk("rst_q104", CoreRdDataQ104H, 0);
    CoreRdQ103H = 1'b0;
    tick(); RstQnnnL = 1'b1;
    tick(); @(negedge QClk);
    chk("rel_rdy", F2mReqReady, 1);

    // Core read, then core write
    tick(); CoreRdQ103H = 1'b1; CoreAdrsQ103H = 32'h400;
    @(negedge QClk);
    chk("crd_memrd", {MemRd, MemWr, CoreStallQ103H}, 3'b100);
    chk("crd_adrs", MemAdrs, 32'h400);
    tick(); CoreRdQ103H = 1'b0;
    CoreWrQ103H = 1'b1; CoreAdrsQ103H = 32'h404; CoreWrDataQ103H = 32'h11223344; CoreByteEnQ103H = 4'h3;
    @(negedge QClk);
    chk("crd_data", CoreRdDataQ104H, 32'hDEADBEEF);
    chk("cwr_mem", {MemRd, MemWr, MemByteEn}, {2'b01, 4'h3});
    chk("cwr_data", {MemAdrs, MemWrData}, {32'h404, 32'h11223344});
    tick(); CoreWrQ103H = 1'b0;
    @(negedge QClk);
    chk("cwr_q104", CoreRdDataQ104H, 0);
    repeat (3) tick();
    chk("core_no_rsp", n_rsp, 0);

    // Fabric read on idle core: issue next cycle, response two cycles after issue
    fsend(1'b0, 32'h800, 32'h0, 4'd3);
    @(negedge QClk);
    chk("fab_issue", {MemRd, MemWr, MemAdrs}, {2'b10, 32'h800});
    @(negedge QClk);
    chk("fab_lat1", M2fRspValid, 0);
    @(negedge QClk);
    chk("fab_lat2", {M2fRspValid, M2fRspTag}, {1'b1, 4'd3});
    drain("fab_drain");

    // Backpressure: credit limit of 2 outstanding, request FIFO fills
    tick(); M2fRspReady = 1'b0; rd0 = n_rd;
    for (int i = 0; i < 4; i++) fsend(1'b0, 32'h900 + 32'(i * 16), 32'h0, 4'(4 + i));
    repeat (3) tick();
    @(negedge QClk);
    chk("bp_rdy", F2mReqReady, 0);
    chk("bp_issued", n_rd - rd0, 2);
    chk("bp_head", {M2fRspValid, M2fRspTag}, {1'b1, 4'd4});
    tick(); M2fRspReady = 1'b1;
    drain("bp_drain");
    chk("bp_all_issued", n_rd - rd0, 4);

    // Push and issue in the same cycle with one entry held
    CoreRdQ103H = 1'b1; CoreAdrsQ103H = 32'h100;
    fsend(1'b0, 32'hA00, 32'h0, 4'd8);
    @(negedge QClk);
    chk("pp_core", {F2mReqReady, MemAdrs}, {1'b1, 32'h100});
    tick(); CoreRdQ103H = 1'b0;
    F2mReqValid = 1'b1; F2mReqWr = 1'b0; F2mReqAdrs = 32'hA10; F2mReqTag = 4'd9;
    @(negedge QClk);
    chk("pp_rdy", F2mReqReady, 1);
    chk("pp_issue_a", {MemRd, MemAdrs}, {1'b1, 32'hA00});
    rsp_q.push_back({4'd9, hash(32'hA10)});
    tick(); F2mReqValid = 1'b0;
    @(negedge QClk);
    chk("pp_issue_b", {F2mReqReady, MemRd, MemAdrs}, {2'b11, 32'hA10});
    drain("pp_drain");

    // Starvation: core reads continuously while a fabric write waits
    tick(); CoreRdQ103H = 1'b1; CoreAdrsQ103H = 32'h200;
    st0 = n_stall; wr0 = n_wr; first_wr = 0;
    fsend(1'b1, 32'hC00, 32'hCAFEF00D, 4'd10);
    for (int i = 1; i <= 20; i++) begin
      @(negedge QClk);
      if (MemWr && first_wr == 0) begin
        first_wr = i;
        chk("sv_wr", {CoreStallQ103H, MemAdrs, MemWrData}, {1'b1, 32'hC00, 32'hCAFEF00D});
      end
    end
`ifdef MMIO_DMEM_ARB_STARVE_EN
    chk("sv_when", first_wr, 9);
    chk("sv_stalls", n_stall - st0, 1);
`else
    chk("sv_when", first_wr, 0);
    chk("sv_stalls", n_stall - st0, 0);
`endif
    tick(); CoreRdQ103H = 1'b0;
    drain("sv_drain");
    chk("sv_wr_cnt", n_wr - wr0, 1);

    // Reset mid-operation with queued and buffered requests
    tick(); M2fRspReady = 1'b0;
    for (int i = 0; i < 4; i++) fsend(1'b0, 32'hB00 + 32'(i * 4), 32'h0, 4'(11 + i));
    @(posedge QClk); #3; RstQnnnL = 1'b0; #1;
    chk("mrst_out", {F2mReqReady, M2fRspValid, MemRd, MemWr, M2fRspTag}, 0);
    chk("mrst_data", {M2fRspData, CoreRdDataQ104H}, 0);
    rsp_q.delete();
    tick(); tick(); RstQnnnL = 1'b1; M2fRspReady = 1'b1; rsp0 = n_rsp; rd0 = n_rd;
    tick(); @(negedge QClk);
    chk("mrst_rdy", F2mReqReady, 1);
    repeat (8) tick();
    chk("mrst_no_rsp", n_rsp - rsp0, 0);
    chk("mrst_no_issue", n_rd - rd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end
endmodule
